// File: rtl/card_board_if.sv
// card_board_if: board load, flip request and board status signals between the game controller and its host.
interface card_board_if;
    logic        load;
    logic [0:47] card_vals;
    logic        flip_req;
    logic [3:0]  flip_idx;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic [2:0]  last_val;
    logic        match_pulse;
    logic        mismatch_pulse;
    logic        flip_reject;
    logic [3:0]  pairs_found;
    logic        game_over;
    logic [2:0]  state;
    modport master (
        output load, card_vals, flip_req, flip_idx,
        input  face_up, matched, last_val, match_pulse, mismatch_pulse,
               flip_reject, pairs_found, game_over, state
    );
    modport slave (
        input  load, card_vals, flip_req, flip_idx,
        output face_up, matched, last_val, match_pulse, mismatch_pulse,
               flip_reject, pairs_found, game_over, state
    );
endinterface

// File: rtl/card_board_ctrl.sv
// card_board_ctrl: memory-game board controller; latches the shuffled board, pairs up flips, holds mismatches, tracks the win.
module card_board_ctrl #(
    parameter int HOLD_CYCLES = 25_000_000
) (
    input logic         clk,
    input logic         resetn,
    card_board_if.slave bus
);
    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [2:0] IDLE = 3'd0, WAIT_FIRST = 3'd1, WAIT_SECOND = 3'd2,
                           COMPARE = 3'd3, HOLD = 3'd4, DONE = 3'd5;
    logic [0:47]   board;
    logic [3:0]    first, second;
    logic [CW-1:0] cnt;
    logic [5:0]    fb, ab, bb;
    logic [2:0]    fval, aval, bval;
    logic          take;
    assign fb   = 6'(bus.flip_idx) * 6'd3;
    assign ab   = 6'(first) * 6'd3;
    assign bb   = 6'(second) * 6'd3;
    assign fval = board[fb +: 3];
    assign aval = board[ab +: 3];
    assign bval = board[bb +: 3];
    assign take = bus.flip_req && !bus.face_up[bus.flip_idx] && !bus.matched[bus.flip_idx] &&
                  (bus.state == WAIT_FIRST || bus.state == WAIT_SECOND);
    assign bus.game_over = bus.state == DONE;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.state          <= IDLE;
            bus.face_up        <= '0;
            bus.matched        <= '0;
            bus.last_val       <= '0;
            bus.pairs_found    <= '0;
            bus.match_pulse    <= 1'b0;
            bus.mismatch_pulse <= 1'b0;
            bus.flip_reject    <= 1'b0;
            board              <= '0;
            first              <= '0;
            second             <= '0;
            cnt                <= '0;
        end else begin
            bus.match_pulse    <= 1'b0;
            bus.mismatch_pulse <= 1'b0;
            bus.flip_reject    <= bus.flip_req && !bus.load && !take;
            if (bus.load) begin
                board           <= bus.card_vals;
                bus.face_up     <= '0;
                bus.matched     <= '0;
                bus.pairs_found <= '0;
                cnt             <= '0;
                bus.state       <= WAIT_FIRST;
            end else begin
                if (take) begin
                    bus.face_up[bus.flip_idx] <= 1'b1;
                    bus.last_val              <= fval;
                    if (bus.state == WAIT_FIRST) begin
                        first     <= bus.flip_idx;
                        bus.state <= WAIT_SECOND;
                    end else begin
                        second    <= bus.flip_idx;
                        bus.state <= COMPARE;
                    end
                end
                if (bus.state == COMPARE) begin
                    if (aval == bval) begin
                        bus.matched[first]  <= 1'b1;
                        bus.matched[second] <= 1'b1;
                        bus.pairs_found     <= bus.pairs_found + 4'(bus.pairs_found != 4'd8);
                        bus.match_pulse     <= 1'b1;
                        bus.state           <= bus.pairs_found >= 4'd7 ? DONE : WAIT_FIRST;
                    end else begin
                        bus.mismatch_pulse <= 1'b1;
                        cnt                <= CW'(HOLD_CYCLES - 1);
                        bus.state          <= HOLD;
                    end
                end
                if (bus.state == HOLD) begin
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        bus.face_up[first]  <= 1'b0;
                        bus.face_up[second] <= 1'b0;
                        bus.state           <= WAIT_FIRST;
                    end
                end
            end
        end
    end
endmodule

// File: doc/card_board_ctrl.md
# card_board_ctrl

Game-board controller directly downstream of the random start generator. Latches the 48-bit shuffled board (16 cards × 3-bit value) when the generator signals done. Accepts player flip requests, tracks face-up and matched cards, compares each pair of flips and holds mismatched pairs visible for a fixed time. Drives the board display and the win indication.

## Interface
- HOLD_CYCLES, 25_000_000, cycles a mismatched pair stays face-up (≥2; bench uses 8)
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- load  in  1  generator done; latch card_vals while high
- card_vals  in  [0:47]  board; card i value = card_vals[3i:3i+2], MSB first
- flip_req  in  1  one-cycle flip request
- flip_idx  in  4  card index 0–15 for flip_req
- face_up  out  16  bit i = card i currently shown
- matched  out  16  bit i = card i permanently matched
- last_val  out  3  value of most recently accepted flip
- match_pulse  out  1  one cycle, pair matched
- mismatch_pulse  out  1  one cycle, pair mismatched
- flip_reject  out  1  one cycle, flip_req ignored
- pairs_found  out  4  matched pairs, 0–8
- game_over  out  1  high in DONE
- state  out  3  IDLE=0, WAIT_FIRST=1, WAIT_SECOND=2, COMPARE=3, HOLD=4, DONE=5

## Operation
- Reset: state IDLE; face_up, matched, board, first/second index, last_val, pairs_found, hold counter all 0; all pulses 0; game_over 0.
- load high at an edge, any state, has priority over everything: board←card_vals, face_up←0, matched←0, pairs_found←0, hold counter←0, state→WAIT_FIRST; flip_req that cycle ignored, no flip_reject.
- Eligible flip: flip_idx not face_up and not matched.
- IDLE: flip_req → flip_reject.
- WAIT_FIRST: eligible flip → face_up[idx]←1, first←idx, last_val←value, →WAIT_SECOND; ineligible → flip_reject.
- WAIT_SECOND: eligible flip (necessarily ≠ first) → face_up[idx]←1, second←idx, last_val←value, →COMPARE; ineligible → flip_reject.
- COMPARE (one cycle, flip_req → flip_reject): values equal → matched[first], matched[second]←1, face_up both stay 1, pairs_found+1, match_pulse; →DONE if pairs_found becomes 8, else WAIT_FIRST. Unequal → mismatch_pulse, counter←HOLD_CYCLES−1, →HOLD.
- HOLD: counter decrements each edge; at edge where counter==0: face_up[first], face_up[second]←0, →WAIT_FIRST. flip_req → flip_reject.
- DONE: game_over=1; flip_req → flip_reject; only load or reset exits.
- pairs_found saturates at 8; matched cards are never cleared except by load/reset.
- Board contents are not validated (duplicate-count errors in card_vals are just played as given).

## Timing
- All outputs registered; pulses are exactly one cycle.
- Flip accepted at edge E: face_up and last_val updated after E.
- Second flip at edge E: COMPARE during E→E+1; match_pulse/mismatch_pulse and matched/pairs_found updates visible after E+1.
- Mismatch: HOLD occupies HOLD_CYCLES cycles; face_up bits cleared after edge E+1+HOLD_CYCLES; next flip accepted at that edge+1 earliest.
- Match: next flip accepted at edge E+2 earliest.
- flip_reject is asserted the cycle after the rejected request's edge.
- Reset mid-HOLD or mid-COMPARE: immediate return to reset values, no pulse emitted.

## Test plan
- Reset then load board with card i value = i/2 (0,0,1,1,…,7,7): state=1, face_up=0, matched=0, pairs_found=0.
- Flip 0 then 1 → match_pulse one cycle 2 edges after second flip; matched=16'h0003, face_up=16'h0003, pairs_found=1, last_val=0.
- Flip 2 then 4 (HOLD_CYCLES=8) → mismatch_pulse; face_up bits 2,4 held exactly 8 cycles then cleared; flip 6 during HOLD → flip_reject, no change.
- Flip 0 (matched), flip 3 twice in a row, flip in IDLE → flip_reject each, state unchanged.
- Flip all 8 pairs in order → pairs_found=8, matched=16'hFFFF, state=5, game_over=1; further flips rejected; load returns to WAIT_FIRST with all cleared.
- Assert resetn=0 mid-HOLD and load pulse mid-WAIT_SECOND → all outputs at reset values / board reloaded, face_up=0, no match or mismatch pulse.
